i2s_transmitter: RTL and testbench



---
 rtl/i2s_transmitter_pkg.sv | 15 +
 rtl/i2s_bclk_gen.sv | 47 ++++
 rtl/i2s_transmitter.sv | 131 +++++++++++++
 tb/tb_i2s_transmitter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// i2s_transmitter_pkg
// Constants and types shared by the I2S transmitter and its bit-clock generator.
//   I2S_SAMPLE_WIDTH      : mixed sample width in bits (two's complement)
//   I2S_SLOTS_PER_CHANNEL : bclk periods per channel (half of one stereo frame)
//   sample_t              : signed mixed-sample type
// -----------------------------------------------------------------------------
package i2s_transmitter_pkg;

    localparam int I2S_SAMPLE_WIDTH      = 24;
    localparam int I2S_SLOTS_PER_CHANNEL = 32;

    typedef logic signed [I2S_SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// -----------------------------------------------------------------------------
// i2s_bclk_gen
// Divides the system clock down to the I2S bit clock.
//   clk_i        : system clock
//   rst_i        : synchronous active-high reset
//   bclk_o       : bit clock, toggles every BCLK_DIV system clocks
//   fall_event_o : one-cycle pulse on the system-clock edge where bclk falls
// -----------------------------------------------------------------------------
module i2s_bclk_gen
    import i2s_transmitter_pkg::*;
#(
    parameter int BCLK_DIV = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic bclk_o,
    output logic fall_event_o
);

    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          bclk_q, bclk_d;
    logic          wrap;

    always_comb begin
        wrap   = (div_q == DW'(BCLK_DIV - 1));
        div_d  = wrap ? '0 : div_q + 1'b1;
        bclk_d = wrap ? ~bclk_q : bclk_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk_o       = bclk_q;
    // Combinational so that the consumer's registers change on the same
    // edge that takes bclk low.
    assign fall_event_o = wrap & bclk_q;

endmodule

// File: rtl/i2s_transmitter.sv
// -----------------------------------------------------------------------------
// i2s_transmitter
// Accepts mono mixed samples over valid/ready and sends each one as a stereo
// I2S frame (same sample on left and right), acting as bclk/lrclk master.
//   clock        : system clock
//   reset        : synchronous active-high reset
//   sample_in    : mixed sample, two's complement
//   sample_valid : sample_in is valid
//   sample_ready : holding register empty (combinational)
//   bclk         : I2S bit clock
//   lrclk        : I2S word select, 0 = left, 1 = right
//   sdata        : I2S serial data, MSB first, one-bclk delay after lrclk
// Build option: define I2S_UNDERRUN_MUTE_EN to send silence on underrun
// instead of repeating the previous sample.
// -----------------------------------------------------------------------------
module i2s_transmitter
    import i2s_transmitter_pkg::*;
#(
    parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
    parameter int BCLK_DIV     = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           sample_valid,
    output logic                           sample_ready,
    output logic                           bclk,
    output logic                           lrclk,
    output logic                           sdata
);

    localparam int CW = $clog2(2 * I2S_SLOTS_PER_CHANNEL);
    localparam int SW = $clog2(I2S_SLOTS_PER_CHANNEL);
    localparam int IW = $clog2(SAMPLE_WIDTH);

    logic                    fall_event;
    logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic [SAMPLE_WIDTH-1:0] latch_q, latch_d;
    logic [CW-1:0]           bit_count_q, bit_count_d;
    logic                    lrclk_q, lrclk_d;
    logic                    sdata_q, sdata_d;

    logic                    accept;
    logic                    frame_start;
    logic [CW-1:0]           count_inc;
    logic [SW-1:0]           slot;
    logic [IW-1:0]           bit_idx;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk_i        (clock),
        .rst_i        (reset),
        .bclk_o       (bclk),
        .fall_event_o (fall_event)
    );

    always_comb begin
        accept      = sample_valid && !hold_full_q;
        frame_start = fall_event && (bit_count_q == '1);
        count_inc   = bit_count_q + 1'b1;
        slot        = count_inc[SW-1:0];
        bit_idx     = IW'(SAMPLE_WIDTH - int'(slot));

        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        latch_d     = latch_q;
        bit_count_d = bit_count_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;

        if (accept) begin
            hold_d = sample_in;
        end

        // Frame start looks at hold_full before this edge: an accept on the
        // same edge can only happen when empty, and it waits a frame.
        if (frame_start && hold_full_q) begin
            hold_full_d = 1'b0;
        end else if (accept) begin
            hold_full_d = 1'b1;
        end

        if (frame_start) begin
            if (hold_full_q) begin
                latch_d = hold_q;
            end else begin
`ifdef I2S_UNDERRUN_MUTE_EN
                latch_d = '0;
`else
                latch_d = latch_q;
`endif
            end
        end

        if (fall_event) begin
            bit_count_d = count_inc;
            lrclk_d     = count_inc[CW-1];
            sdata_d     = 1'b0;
            // Slot 0 is the I2S delay bit; the latch only changes at slot 0,
            // so reading latch_q here never sees a half-updated frame.
            if ((slot != '0) && (int'(slot) <= SAMPLE_WIDTH)) begin
                sdata_d = latch_q[bit_idx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            latch_q     <= '0;
            bit_count_q <= '0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            latch_q     <= latch_d;
            bit_count_q <= bit_count_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
        end
    end

    assign sample_ready = !hold_full_q;
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// -----------------------------------------------------------------------------
// tb_i2s_transmitter
// Directed bench for i2s_transmitter at default parameters (BCLK_DIV = 8).
// Frames are captured as a receiver would: sdata/lrclk sampled at bclk rise,
// slot 0 of the left channel first. Honours I2S_UNDERRUN_MUTE_EN.
// -----------------------------------------------------------------------------
module tb_i2s_transmitter;
    import i2s_transmitter_pkg::*;

    logic    clock;
    logic    reset;
    sample_t sample_in;
    logic    sample_valid;
    logic    sample_ready;
    logic    bclk;
    logic    lrclk;
    logic    sdata;

    int unsigned errors = 0;
    int unsigned checks = 0;

    localparam logic [63:0] LR_PATTERN = 64'h0000_0000_FFFF_FFFF;

    i2s_transmitter #(
        .SAMPLE_WIDTH (24),
        .BCLK_DIV     (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one system clock and settle away from the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_bclk_rise(output bit ok);
        logic prev;
        prev = bclk;
        ok   = 1'b0;
        for (int n = 0; n < 64; n++) begin
            step();
            if (bclk && !prev) begin
                ok = 1'b1;
                return;
            end
            prev = bclk;
        end
    endtask

    task automatic wait_bclk_fall(output bit ok);
        logic prev;
        prev = bclk;
        ok   = 1'b0;
        for (int n = 0; n < 64; n++) begin
            step();
            if (!bclk && prev) begin
                ok = 1'b1;
                return;
            end
            prev = bclk;
        end
    endtask

    // Returns just after the edge where lrclk falls (start of left slot 0).
    task automatic wait_frame_start(output bit ok);
        logic prev;
        prev = lrclk;
        ok   = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            step();
            if (!lrclk && prev) begin
                ok = 1'b1;
                return;
            end
            prev = lrclk;
        end
    endtask

    // Call just after a frame start; collects 64 slots.
    task automatic capture(output logic [31:0] left, output logic [31:0] right,
                           output logic [63:0] lr, output bit ok);
        logic [63:0] bits;
        bit          o;
        ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            wait_bclk_rise(o);
            if (!o) ok = 1'b0;
            bits[63-i] = sdata;
            lr[63-i]   = lrclk;
        end
        left  = bits[63:32];
        right = bits[31:0];
    endtask

    // Presents v with valid high until the edge on which it is accepted.
    task automatic push(input sample_t v, output bit ok);
        sample_in    = v;
        sample_valid = 1'b1;
        ok           = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (sample_ready) begin
                step();
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    logic [31:0] l, r;
    logic [63:0] lr;
    logic [31:0] l3 [3];
    logic [31:0] r3 [3];
    bit          ok, ok_push, ok_cap;
    int unsigned period;
    logic        prev_b;

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;

        // Reset state
        repeat (4) step();
        check("rst_bclk",  64'(bclk),  64'd0);
        check("rst_lrclk", 64'(lrclk), 64'd0);
        check("rst_sdata", 64'(sdata), 64'd0);
        check("rst_ready", 64'(sample_ready), 64'd1);
        reset = 1'b0;

        // First frame after reset: latch is zero, lrclk 32 slots low / 32 high
        capture(l, r, lr, ok);
        check("f0_timeout", 64'(ok), 64'd1);
        check("f0_left",  64'(l), 64'h0);
        check("f0_right", 64'(r), 64'h0);
        check("f0_lrclk", lr, LR_PATTERN);

        // bclk period in system clocks
        period = 0;
        prev_b = bclk;
        for (int n = 0; n < 64; n++) begin
            step();
            period++;
            if (bclk && !prev_b) break;
            prev_b = bclk;
        end
        check("bclk_period", 64'(period), 64'd16);

        // Single sample 3FFFFF
        push(24'h3FFFFF, ok);
        sample_valid = 1'b0;
        check("p1_accept", 64'(ok), 64'd1);
        check("p1_ready_low", 64'(sample_ready), 64'd0);
        wait_frame_start(ok);
        check("p1_fs_timeout", 64'(ok), 64'd1);
        check("p1_ready_high", 64'(sample_ready), 64'd1);
        capture(l, r, lr, ok);
        check("p1_left",  64'(l), 64'h1FFF_FF80);
        check("p1_right", 64'(r), 64'h1FFF_FF80);
        check("p1_lrclk", lr, LR_PATTERN);

        // 800001: MSB and LSB set
        push(24'h800001, ok);
        sample_valid = 1'b0;
        check("p2_ready_low", 64'(sample_ready), 64'd0);
        wait_frame_start(ok);
        check("p2_fs_timeout", 64'(ok), 64'd1);
        capture(l, r, lr, ok);
        check("p2_left",  64'(l), 64'h4000_0080);
        check("p2_right", 64'(r), 64'h4000_0080);

        // Valid held high across three samples; one accepted per frame
        fork
            begin
                bit o1, o2, o3;
                push(24'h000003, o1);
                push(24'h000001, o2);
                push(24'h000002, o3);
                sample_valid = 1'b0;
                ok_push = o1 && o2 && o3;
            end
            begin
                bit o;
                ok_cap = 1'b1;
                for (int f = 0; f < 3; f++) begin
                    wait_frame_start(o);
                    if (!o) ok_cap = 1'b0;
                    capture(l3[f], r3[f], lr, o);
                    if (!o) ok_cap = 1'b0;
                end
            end
        join
        check("seq_push",    64'(ok_push), 64'd1);
        check("seq_capture", 64'(ok_cap),  64'd1);
        check("seq0_left",  64'(l3[0]), 64'h0000_0180);
        check("seq0_right", 64'(r3[0]), 64'h0000_0180);
        check("seq1_left",  64'(l3[1]), 64'h0000_0080);
        check("seq1_right", 64'(r3[1]), 64'h0000_0080);
        check("seq2_left",  64'(l3[2]), 64'h0000_0100);
        check("seq2_right", 64'(r3[2]), 64'h0000_0100);

        // 00000F then underrun
        push(24'h00000F, ok);
        sample_valid = 1'b0;
        wait_frame_start(ok);
        capture(l, r, lr, ok);
        check("ur_load_left",  64'(l), 64'h0000_0780);
        check("ur_load_right", 64'(r), 64'h0000_0780);
        wait_frame_start(ok);
        check("ur_fs_timeout", 64'(ok), 64'd1);
        capture(l, r, lr, ok);
`ifdef I2S_UNDERRUN_MUTE_EN
        check("ur_left",  64'(l), 64'h0);
        check("ur_right", 64'(r), 64'h0);
`else
        check("ur_left",  64'(l), 64'h0000_0780);
        check("ur_right", 64'(r), 64'h0000_0780);
`endif

        // Reset at bit_count 40 with a sample pending in the holding register
        wait_frame_start(ok);
        push(24'h5A5A5A, ok);
        sample_valid = 1'b0;
        for (int n = 0; n < 40; n++) wait_bclk_fall(ok);
        check("mid_lrclk", 64'(lrclk), 64'd1);
        check("mid_ready", 64'(sample_ready), 64'd0);
        reset = 1'b1;
        step();
        check("mr_bclk",  64'(bclk),  64'd0);
        check("mr_lrclk", 64'(lrclk), 64'd0);
        check("mr_sdata", 64'(sdata), 64'd0);
        check("mr_ready", 64'(sample_ready), 64'd1);
        reset = 1'b0;
        capture(l, r, lr, ok);
        check("mr_f0_left",  64'(l), 64'h0);
        check("mr_f0_right", 64'(r), 64'h0);
        check("mr_f0_lrclk", lr, LR_PATTERN);
        wait_frame_start(ok);
        check("mr_fs_timeout", 64'(ok), 64'd1);
        capture(l, r, lr, ok);
        check("mr_f1_left",  64'(l), 64'h0);
        check("mr_f1_right", 64'(r), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
